eq2_sop_cmp: RTL and testbench

Registered 2-bit equality comparator built as an explicit sum-of-products (SOP) of four minterm product terms. Each clock it compares two 2-bit operands `a` and `b` and drives `aeqb` high when they are bit-for-bit identical. It is a leaf datapath element for small compare/match logic and a reference block for the gate-level SOP coding style used in the project's combinational examples.

---
 rtl/eq2_sop_cmp_if.sv | 22 ++
 rtl/eq2_sop_cmp.sv | 42 ++++
 tb/tb_eq2_sop_cmp.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/eq2_sop_cmp_if.sv
// Operand/result bundle for the registered 2-bit SOP equality comparator.
// There is no handshake: operands are sampled on every rising clock edge and results follow one edge later.
interface eq2_sop_cmp_if;
    logic [1:0] a;
    logic [1:0] b;
    logic       aeqb;
    logic [3:0] pterm;

    modport master (
        output a,
        output b,
        input  aeqb,
        input  pterm
    );

    modport slave (
        input  a,
        input  b,
        output aeqb,
        output pterm
    );
endinterface

// File: rtl/eq2_sop_cmp.sv
// Registered 2-bit equality comparator coded as an explicit sum of four minterm products.
// The pterm output exposes the registered product terms for debug and checking.
module eq2_sop_cmp (
    input  logic          clk,
    input  logic          reset,
    eq2_sop_cmp_if.slave  cmp
);
    logic       a1;
    logic       a0;
    logic       b1;
    logic       b0;
    logic [3:0] p;
    logic       eq_next;
    logic       aeqb_q;
    logic [3:0] pterm_q;

    assign a1 = cmp.a[1];
    assign a0 = cmp.a[0];
    assign b1 = cmp.b[1];
    assign b0 = cmp.b[0];

    // One minterm per operand value; at most one can be true for any input pair.
    assign p[0] = ~a1 & ~a0 & ~b1 & ~b0;
    assign p[1] = ~a1 &  a0 & ~b1 &  b0;
    assign p[2] =  a1 & ~a0 &  b1 & ~b0;
    assign p[3] =  a1 &  a0 &  b1 &  b0;

    assign eq_next = p[0] | p[1] | p[2] | p[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            aeqb_q  <= 1'b0;
            pterm_q <= 4'b0000;
        end else begin
            aeqb_q  <= eq_next;
            pterm_q <= {p[3], p[2], p[1], p[0]};
        end
    end

    assign cmp.aeqb  = aeqb_q;
    assign cmp.pterm = pterm_q;
endmodule

// File: tb/tb_eq2_sop_cmp.sv
// Directed bench for eq2_sop_cmp: reset, equal/unequal vectors, exhaustive pairs, mid-stream reset, toggling.
module tb_eq2_sop_cmp;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    eq2_sop_cmp_if bus ();

    eq2_sop_cmp dut (
        .clk   (clk),
        .reset (reset),
        .cmp   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.a = 2'b11;
        bus.b = 2'b11;
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if (bus.aeqb !== 1'b0 || bus.pterm !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d aeqb=%b pterm=%b required aeqb=0 pterm=0000", i, bus.aeqb, bus.pterm);
            end
        end
        reset = 1'b0;
        cycle();
        vectors++;
        if (bus.aeqb !== 1'b1 || bus.pterm !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_release aeqb=%b pterm=%b required aeqb=1 pterm=1000", bus.aeqb, bus.pterm);
        end
    endtask

    task automatic test_equal_sweep();
        logic [3:0] exp_p [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int k = 0; k < 4; k++) begin
            bus.a = 2'(k);
            bus.b = 2'(k);
            cycle();
            vectors++;
            if (bus.aeqb !== 1'b1 || bus.pterm !== exp_p[k]) begin
                miscompares++;
                $display("FAIL equal_sweep k=%0d aeqb=%b pterm=%b required aeqb=1 pterm=%b", k, bus.aeqb, bus.pterm, exp_p[k]);
            end
        end
    endtask

    task automatic test_unequal();
        logic [1:0] va [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] vb [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        for (int v = 0; v < 4; v++) begin
            bus.a = va[v];
            bus.b = vb[v];
            for (int c = 0; c < 10; c++) begin
                cycle();
                vectors++;
                if (bus.aeqb !== 1'b0 || bus.pterm !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL unequal a=%b b=%b cyc=%0d aeqb=%b pterm=%b required aeqb=0 pterm=0000", va[v], vb[v], c, bus.aeqb, bus.pterm);
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [1:0] av;
        logic [1:0] bv;
        logic       exp_eq;
        logic [3:0] exp_p;
        for (int i = 0; i < 16; i++) begin
            av = 2'(i >> 2);
            bv = 2'(i);
            exp_eq = (av == bv);
            exp_p  = exp_eq ? (4'b0001 << av) : 4'b0000;
            bus.a = av;
            bus.b = bv;
            cycle();
            vectors++;
            if (bus.aeqb !== exp_eq || bus.pterm !== exp_p) begin
                miscompares++;
                $display("FAIL exhaustive a=%b b=%b aeqb=%b pterm=%b required aeqb=%b pterm=%b", av, bv, bus.aeqb, bus.pterm, exp_eq, exp_p);
            end
            vectors++;
            if (!$onehot0(bus.pterm) || ((|bus.pterm) !== bus.aeqb)) begin
                miscompares++;
                $display("FAIL invariant a=%b b=%b aeqb=%b pterm=%b required onehot0 pterm with |pterm==aeqb", av, bv, bus.aeqb, bus.pterm);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic       exp_a [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] exp_p [3] = '{4'b0100, 4'b0000, 4'b0100};
        logic       rst_v [3] = '{1'b0, 1'b1, 1'b0};
        bus.a = 2'b10;
        bus.b = 2'b10;
        for (int s = 0; s < 3; s++) begin
            reset = rst_v[s];
            cycle();
            vectors++;
            if (bus.aeqb !== exp_a[s] || bus.pterm !== exp_p[s]) begin
                miscompares++;
                $display("FAIL mid_reset step=%0d aeqb=%b pterm=%b required aeqb=%b pterm=%b", s, bus.aeqb, bus.pterm, exp_a[s], exp_p[s]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic       exp_eq;
        logic [3:0] exp_p;
        for (int i = 0; i < 8; i++) begin
            bus.a = 2'b01;
            bus.b = (i % 2 == 0) ? 2'b01 : 2'b11;
            exp_eq = (i % 2 == 0);
            exp_p  = exp_eq ? 4'b0010 : 4'b0000;
            cycle();
            vectors++;
            if (bus.aeqb !== exp_eq || bus.pterm !== exp_p) begin
                miscompares++;
                $display("FAIL back_to_back i=%0d aeqb=%b pterm=%b required aeqb=%b pterm=%b", i, bus.aeqb, bus.pterm, exp_eq, exp_p);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.a       = 2'b00;
        bus.b       = 2'b00;
        test_reset();
        test_equal_sweep();
        test_unequal();
        test_exhaustive();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
